fetch_decode_queue: RTL and testbench

Parametrised fetch-to-decode channel: a DEPTH-entry FIFO of fetch packets with valid/ready handshakes on both sides and a synchronous flush for redirects. It replaces the single-slot busy-flag bus between the fetch and decode stages. Fetch can run up to DEPTH packets ahead of decode, and a branch redirect discards all in-flight packets in one cycle.

---
 rtl/fetch_decode_queue.sv | 122 ++++++++++++
 tb/tb_fetch_decode_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//
// Fetch-to-decode channel: a DEPTH-entry FIFO of fetch packets with
// valid/ready handshakes on both sides and a synchronous flush used on
// branch redirects. Fetch may run up to DEPTH packets ahead of decode.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   flush      - discard all entries at the next edge (top priority)
//   in_valid   - fetch presents a packet
//   in_data    - packet from fetch
//   in_ready   - queue accepts a packet this cycle (count != DEPTH)
//   out_valid  - head entry valid for decode (count != 0)
//   out_data   - head packet, mem[rp]
//   out_ready  - decode consumes the head this cycle
//   count      - number of valid entries, 0..DEPTH
//   busy       - count != 0
//   proto_err  - sticky: stalled head changed while held
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (push = in_valid & in_ready, pop = out_valid & out_ready).
// A producer holds valid/data until the transfer; ready never depends on
// the partner's valid. in_ready is derived from count only, so a full queue
// does not accept a packet in the same cycle it pops one.

module fetch_decode_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              proto_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic [CNT_W-1:0]  cnt;
    logic              push;
    logic              pop;

    // Stability monitor state: the head value and whether the head was
    // valid-and-stalled in the previous cycle.
    logic [DATA_W-1:0] prev_data;
    logic              prev_hold;
    logic              err;

    assign in_ready  = (cnt != CNT_W'(DEPTH));
    assign out_valid = (cnt != '0);
    assign out_data  = mem[rp];
    assign count     = cnt;
    assign busy      = (cnt != '0);
    assign proto_err = err;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Storage has no reset; contents are only meaningful under count.
    // A flush cycle writes nothing so the discarded packet never lands.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wp] <= in_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two). Full/empty is
    // decided from cnt alone, never from the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + PTR_W'(1);
            end
            if (pop) begin
                rp <= rp + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Only a cycle that follows a valid-and-stalled cycle is checked, so a
    // legitimate head change after a pop (or a fresh head after empty)
    // does not trip the flag. Flush is not a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_data <= '0;
            prev_hold <= 1'b0;
            err       <= 1'b0;
        end else begin
            prev_data <= out_data;
            prev_hold <= out_valid & ~out_ready & ~flush;
            if (prev_hold && out_valid && !out_ready && (out_data != prev_data)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              proto_err;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                model_cnt = 0;

    fetch_decode_queue #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .count    (count),
        .busy     (busy),
        .proto_err(proto_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard / model ----------------
    // Sampled on the falling edge: checks the flags against the model
    // count, compares popped data with the expected queue, then advances.
    always @(negedge clk) begin
        logic do_push;
        logic do_pop;
        if (!rst_n) begin
            model_cnt = 0;
            exp_q.delete();
        end else begin
            check_eq("count", 64'(count), 64'(model_cnt));
            check_eq("in_ready", 64'(in_ready), 64'(model_cnt != DEPTH));
            check_eq("out_valid", 64'(out_valid), 64'(model_cnt != 0));
            check_eq("busy", 64'(busy), 64'(model_cnt != 0));
            check_eq("proto_err", 64'(proto_err), 64'd0);
            do_pop  = out_ready && (model_cnt != 0) && !flush;
            do_push = in_valid && (model_cnt != DEPTH) && !flush;
            if (do_pop) begin
                check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check_eq("out_data", out_data, exp_q.pop_front());
                end
            end
            if (do_push) exp_q.push_back(in_data);
            if (flush) begin
                exp_q.delete();
                model_cnt = 0;
            end else begin
                model_cnt = model_cnt + int'(do_push) - int'(do_pop);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Applies inputs just after an edge, holds them over the next rising
    // edge and returns 1 time unit after it.
    task automatic cycle(input logic v, input logic [63:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_proto_err", 64'(proto_err), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill then drain
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 64'hA0 + 64'(i), 1'b0, 1'b0);
            check_eq("fill_count", 64'(count), 64'(i + 1));
        end
        check_eq("full_in_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 64'hA4, 1'b0, 1'b0);
        check_eq("fifth_rejected", 64'(count), 64'd4);
        check_eq("full_head", out_data, 64'hA0);
        drain(4);
        check_eq("drain_count", 64'(count), 64'd0);
        check_eq("drain_busy", 64'(busy), 64'd0);

        // Streaming: one push and one pop per cycle
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 64'h10 + 64'(i), 1'b1, 1'b0);
            check_eq("stream_count", 64'(count), 64'd1);
            check_eq("stream_head", out_data, 64'h10 + 64'(i));
        end
        drain(1);

        // Full plus simultaneous request
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'hB0 + 64'(i), 1'b0, 1'b0);
        check_eq("b_full", 64'(count), 64'd4);
        cycle(1'b1, 64'hB4, 1'b1, 1'b0);
        check_eq("full_pop_only", 64'(count), 64'd3);
        cycle(1'b1, 64'hB4, 1'b0, 1'b0);
        check_eq("refill", 64'(count), 64'd4);
        drain(4);

        // Flush mid-stream
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'hC0 + 64'(i), 1'b0, 1'b0);
        check_eq("pre_flush", 64'(count), 64'd3);
        cycle(1'b1, 64'hC3, 1'b1, 1'b1);
        check_eq("flush_count", 64'(count), 64'd0);
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        check_eq("flush_in_ready", 64'(in_ready), 64'd1);
        cycle(1'b1, 64'h55, 1'b0, 1'b0);
        check_eq("post_flush_valid", 64'(out_valid), 64'd1);
        check_eq("post_flush_head", out_data, 64'h55);
        check_eq("post_flush_count", 64'(count), 64'd1);
        drain(1);

        // Stall stability
        cycle(1'b1, 64'hD0, 1'b0, 1'b0);
        cycle(1'b1, 64'hD1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 64'd0, 1'b0, 1'b0);
            check_eq("stall_head", out_data, 64'hD0);
            check_eq("stall_proto_err", 64'(proto_err), 64'd0);
        end
        drain(2);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0));
        end
        drain(DEPTH);

        // Asynchronous reset between edges at count=3
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'hE0 + 64'(i), 1'b0, 1'b0);
        check_eq("pre_rst_count", 64'(count), 64'd3);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_count", 64'(count), 64'd0);
        check_eq("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 64'hF0, 1'b0, 1'b0);
        check_eq("post_rst_head", out_data, 64'hF0);
        drain(1);

        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
